// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one icache read at a time, buffers {pc, instr} for decode.
// Optional feature macro: COMPRESSED_FETCH_EN (16-bit compressed instructions, 2-byte PC granularity).
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        icache_read_request,
  output logic [31:0] icache_addr,
  input  logic        icache_read_response,
  input  logic [31:0] icache_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_RUN, S_DISCARD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        r_redir_q;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_mem_instr [FIFO_DEPTH];
  logic [31:0]        r_mem_pc    [FIFO_DEPTH];

  logic               w_req;
  logic               w_resp;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_step;
  logic [31:0]        w_data;
  logic [31:0]        w_tgt;
  logic [31:0]        w_addr;

`ifdef COMPRESSED_FETCH_EN
  assign w_step = (icache_read_data[1:0] == 2'b11) ? 32'd4 : 32'd2;
  assign w_data = (icache_read_data[1:0] == 2'b11) ? icache_read_data
                                                   : {16'h0000, icache_read_data[15:0]};
  assign w_tgt  = redirect_pc & 32'hFFFF_FFFE;
  assign w_addr = r_pc;
`else
  assign w_step = 32'd4;
  assign w_data = icache_read_data;
  assign w_tgt  = redirect_pc & 32'hFFFF_FFFC;
  assign w_addr = r_pc & 32'hFFFF_FFFC;
`endif

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_resp = w_req & icache_read_response;
  // A redirect flushes the buffer; any pop in that cycle is moot.
  assign w_push = (r_state == S_RUN) && w_resp && !redirect_valid;
  assign w_pop  = instr_ready && (r_count != '0) && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // An outstanding request cannot be aborted, so a redirect without a response parks in DISCARD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:     if (redirect_valid && w_req && !w_resp) w_state_nxt = S_DISCARD;
      S_DISCARD: if (w_resp) w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_RUN:     w_req = !w_full;
      S_DISCARD: w_req = 1'b1;
      default:   w_req = 1'b0;
    endcase
    if (reset) w_req = 1'b0;
  end

  assign icache_read_request = w_req;
  assign icache_addr         = w_addr;
  assign instr_valid         = !reset && (r_count != '0);
  assign instr               = r_mem_instr[r_rd_ptr];
  assign instr_pc            = r_mem_pc[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_VECTOR;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (redirect_valid) begin
            if (!(w_req && !w_resp)) r_pc <= w_tgt;
          end else if (w_resp) begin
            r_pc <= r_pc + w_step;
          end
        end
        S_DISCARD: begin
          if (w_resp) r_pc <= redirect_valid ? w_tgt : r_redir_q;
        end
        default: r_pc <= r_pc;
      endcase
      if (redirect_valid) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Redirect target and buffer storage carry no reset; validity is tracked by state/count.
  always_ff @(posedge clk) begin
    if (redirect_valid) r_redir_q <= w_tgt;
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= w_data;
      r_mem_pc[r_wr_ptr]    <= r_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a fixed-latency icache responder.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        resp;
  logic [31:0] rdata;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic        ivalid;
  logic        iready;
  logic [31:0] instr;
  logic [31:0] ipc;

  int          lat;
  int          cnt;
  int          nresp;
  bit          cmode;
  int          n_chk;
  int          n_err;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .icache_read_request  (req),
    .icache_addr          (addr),
    .icache_read_response (resp),
    .icache_read_data     (rdata),
    .redirect_valid       (redir_v),
    .redirect_pc          (redir_pc),
    .instr_valid          (ivalid),
    .instr_ready          (iready),
    .instr                (instr),
    .instr_pc             (ipc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] cdata(input logic [31:0] a);
    if (cmode && a == 32'h0) return 32'h0000_4501;
    if (cmode && a == 32'h2) return 32'h0000_0013;
    return {a[23:0], 8'h13};
  endfunction

  // Cache model: responds after lat cycles of continuous request (lat=0 is a same-cycle hit).
  assign resp  = req && (cnt == lat);
  assign rdata = cdata(addr);

  always @(posedge clk) begin
    if (reset || !req || resp) cnt <= 0;
    else                       cnt <= cnt + 1;
    if (reset)     nresp <= 0;
    else if (resp) nresp <= nresp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tk();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    @(negedge clk);
    reset = 1'b1;
    redir_v = 1'b0;
    lat = l;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_vld", ivalid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  logic [31:0] exp_t4;

  initial begin
    n_chk = 0; n_err = 0; cmode = 1'b0;
    reset = 1'b1; redir_v = 1'b0; redir_pc = '0; iready = 1'b1; lat = 1;
`ifdef COMPRESSED_FETCH_EN
    exp_t4 = 32'h46;
`else
    exp_t4 = 32'h44;
`endif

    // T1: one-cycle cache, decode always ready
    iready = 1'b1;
    do_reset(1);
    chk("t1_req0", req, 1); chk("t1_addr0", addr, 32'h0); chk("t1_vld0", ivalid, 0);
    tk(); chk("t1_vld1", ivalid, 0); chk("t1_addr1", addr, 32'h0);
    tk(); chk("t1_vld2", ivalid, 1); chk("t1_pc2", ipc, 32'h0);
    chk("t1_ins2", instr, 32'h0000_0013); chk("t1_addr2", addr, 32'h4);
    tk(); chk("t1_vld3", ivalid, 0); chk("t1_addr3", addr, 32'h4);
    tk(); chk("t1_vld4", ivalid, 1); chk("t1_pc4", ipc, 32'h4);
    chk("t1_ins4", instr, 32'h0000_0413); chk("t1_addr4", addr, 32'h8);

    // T2: decode stalled, buffer fills, then a single pop and a redirect while full
    iready = 1'b0;
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", req, 1); chk("t2_addr", addr, 32'(4 * i));
      tk();
    end
    chk("t2_full_req", req, 0); chk("t2_full_vld", ivalid, 1);
    chk("t2_head", ipc, 32'h0); chk("t2_nresp", nresp, 4);
    tk(); chk("t2_hold_req", req, 0);
    @(negedge clk); iready = 1'b1; #1;
    chk("t2_pop_req", req, 0);
    @(negedge clk); iready = 1'b0; #1;
    chk("t2_refill_req", req, 1); chk("t2_refill_addr", addr, 32'h10);
    tk(); chk("t2_refull_req", req, 0); chk("t2_head2", ipc, 32'h4); chk("t2_nresp2", nresp, 5);
    @(negedge clk); redir_v = 1'b1; redir_pc = 32'h80; #1;
    @(negedge clk); redir_v = 1'b0; #1;
    chk("t2_flush_vld", ivalid, 0); chk("t2_rd_req", req, 1); chk("t2_rd_addr", addr, 32'h80);
    tk(); chk("t2_rd_vld", ivalid, 1); chk("t2_rd_pc", ipc, 32'h80);

    // T3: redirect during a miss parks on the stale address
    iready = 1'b1;
    do_reset(5);
    tk(); tk();
    redir_v = 1'b1; redir_pc = 32'h100; #1;
    chk("t3_c2_addr", addr, 32'h0);
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk); redir_v = 1'b0; #1;
      chk("t3_stale_req", req, 1); chk("t3_stale_addr", addr, 32'h0); chk("t3_stale_vld", ivalid, 0);
    end
    for (int i = 6; i <= 11; i++) begin
      tk(); chk("t3_new_addr", addr, 32'h100); chk("t3_new_vld", ivalid, 0);
    end
    tk(); chk("t3_vld", ivalid, 1); chk("t3_pc", ipc, 32'h100); chk("t3_ins", instr, 32'h0001_0013);

    // T3b: second redirect on the stale response cycle wins
    do_reset(3);
    redir_v = 1'b1; redir_pc = 32'h200; #1;
    @(negedge clk); redir_v = 1'b0; #1; chk("t3b_addr1", addr, 32'h0);
    tk(); chk("t3b_addr2", addr, 32'h0);
    @(negedge clk); redir_v = 1'b1; redir_pc = 32'h300; #1;
    chk("t3b_resp", resp, 1);
    @(negedge clk); redir_v = 1'b0; #1;
    chk("t3b_addr", addr, 32'h300); chk("t3b_vld", ivalid, 0);

    // T4: redirect coincident with a response drops that data
    do_reset(1);
    tk();
    redir_v = 1'b1; redir_pc = 32'h46; #1;
    chk("t4_resp", resp, 1);
    @(negedge clk); redir_v = 1'b0; #1;
    chk("t4_addr", addr, exp_t4); chk("t4_vld", ivalid, 0);
    tk(); chk("t4_vld3", ivalid, 0);
    tk(); chk("t4_vld4", ivalid, 1); chk("t4_pc", ipc, exp_t4);

    // T7: PC wraps at the top of the address space
    iready = 1'b0;
    do_reset(0);
    redir_v = 1'b1; redir_pc = 32'hFFFF_FFFC; #1;
    @(negedge clk); redir_v = 1'b0; #1;
    chk("t7_addr_top", addr, 32'hFFFF_FFFC); chk("t7_vld", ivalid, 0);
    tk(); chk("t7_addr_wrap", addr, 32'h0); chk("t7_pc", ipc, 32'hFFFF_FFFC);

`ifdef COMPRESSED_FETCH_EN
    // T5: compressed then full-width instruction
    cmode = 1'b1;
    do_reset(0);
    chk("t5_addr0", addr, 32'h0);
    tk(); chk("t5_addr1", addr, 32'h2);
    @(negedge clk); iready = 1'b1; #1;
    chk("t5_pc0", ipc, 32'h0); chk("t5_ins0", instr, 32'h0000_4501);
    @(negedge clk); iready = 1'b0; #1;
    chk("t5_pc1", ipc, 32'h2); chk("t5_ins1", instr, 32'h0000_0013);
    cmode = 1'b0;
`endif

    // T6: reset with a request outstanding
    iready = 1'b0;
    do_reset(0);
    tk(); tk();
    @(negedge clk); lat = 5; #1;
    chk("t6_pend_req", req, 1); chk("t6_pend_addr", addr, 32'hC); chk("t6_pend_vld", ivalid, 1);
    @(negedge clk); reset = 1'b1; #1;
    chk("t6_rst_req", req, 0); chk("t6_rst_vld", ivalid, 0);
    @(negedge clk); #1;
    @(negedge clk); reset = 1'b0; #1;
    chk("t6_req", req, 1); chk("t6_addr", addr, 32'h0); chk("t6_vld", ivalid, 0);
    tk(); chk("t6_vld1", ivalid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
